soc_system_sys_pll_reset_seq: RTL
=================================

Name: soc_system_sys_pll_reset_seq

Overview:
Reset and lock sequencer for the system/SDRAM PLL. It pulses the PLL reset and waits for lock, then qualifies lock as stable for a programmable time. It then releases two downstream reset domains in a staggered order. It also retries on lock timeout, recovers on loss of lock, and flags permanent failure. It runs on the PLL reference clock and sits between board reset and the clock-consumer reset inputs.

Parameters:
PLL_RST_CYCLES, 16, width of each pll_rst pulse in refclk cycles (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles from pll_rst deassert to qualified lock (>LOCK_STABLE_CYCLES)
MAX_RETRIES, 3, extra pll_rst attempts after the first timeout before FAIL (0..15)
RST_RELEASE_GAP, 8, cycles between reset_out_0 and reset_out_1 deassertion (>=1)

Ports:
refclk  in  1  clock (PLL reference clock, 50 MHz)
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL locked, asynchronous to refclk
relock_req  in  1  single-cycle software request to re-run the sequence
pll_rst  out  1  PLL reset, active-high
reset_out_0  out  1  reset for the outclk_0 domain, active-high
reset_out_1  out  1  reset for the outclk_1 (phase-shifted SDRAM) domain, active-high
ready  out  1  sequence complete, clocks usable
fail  out  1  retries exhausted
lock_loss_cnt  out  8  saturating count of lock losses while in RELEASE/RUN
retry_cnt  out  4  timeouts since last successful lock or relock_req

Behaviour:
- Clock and reset: one clock, refclk. rst is synchronous and active-high. All outputs are registered.
- Reset values (rst=1): state ASSERT_RST, pll_rst=1, reset_out_0=1, reset_out_1=1, ready=0, fail=0, lock_loss_cnt=0, retry_cnt=0, all timers=0, sync flops=0.
- rst mid-operation: every output returns to its reset value on the next edge, from any state.
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give lk. lk lags pll_locked by 2 cycles.
- Counters: cnt (pulse/stable/gap) and tmo (timeout). Widths are $clog2 of the largest value they must hold.
- ASSERT_RST:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles after rst falls or after state entry.
  - Then go to WAIT_LOCK with tmo=0.
  - relock_req is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0, tmo increments.
  - lk=1 -> QUALIFY with cnt=0.
- QUALIFY:
  - cnt increments while lk=1. tmo keeps running and is not cleared.
  - lk=0 -> back to WAIT_LOCK.
  - cnt reaching LOCK_STABLE_CYCLES-1 -> RELEASE.
  - Timing requirement: reset_out_0 deasserts exactly LOCK_STABLE_CYCLES+3 cycles after a clean pll_locked rise.
- Timeout (WAIT_LOCK or QUALIFY):
  - tmo reaches LOCK_TIMEOUT_CYCLES-1 without entering RELEASE.
  - If retry_cnt==MAX_RETRIES -> FAIL.
  - Otherwise retry_cnt+1 and -> ASSERT_RST.
- RELEASE:
  - reset_out_0=0 from the entry cycle.
  - After RST_RELEASE_GAP cycles, reset_out_1=0 and ready=1 in the same cycle, and the state becomes RUN. retry_cnt clears on that cycle.
- Lock loss (RELEASE or RUN, lk=0):
  - Next cycle: reset_out_0=1, reset_out_1=1, ready=0, pll_rst=1, state ASSERT_RST.
  - lock_loss_cnt increments, saturating at 255.
- relock_req (WAIT_LOCK, QUALIFY, RELEASE, RUN, FAIL):
  - Same action as lock loss, but lock_loss_cnt is not incremented.
  - retry_cnt=0 and fail=0.
  - If relock_req coincides with lock loss, lock_loss_cnt increments exactly once.
- FAIL:
  - pll_rst=1, reset_out_0=1, reset_out_1=1, ready=0, fail=1.
  - Exits only on rst or relock_req.
- Invariants:
  - reset_out_1=0 implies reset_out_0=0.
  - ready=1 exactly when reset_out_1=0.
  - pll_rst=1 implies both reset outputs are 1.

Test Plan:
Use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, RST_RELEASE_GAP=3.
1. Nominal lock: rst released at cycle 0, pll_locked rises at cycle 10 and is held -> pll_rst high cycles 0-3; reset_out_0 falls at cycle 21; reset_out_1 and ready at cycle 24; retry_cnt=0.
2. Lock glitch: pll_locked high 5 cycles, low 1 cycle, high again -> qualification restarts; reset_out_0 falls 11 cycles after the second rise.
3. Lock never asserts -> exactly 3 pll_rst pulses of 4 cycles each, spaced 32 cycles apart; retry_cnt reaches 2, then fail=1 with pll_rst held at 1.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> within 3 cycles both resets=1, ready=0, pll_rst pulses 4 cycles, lock_loss_cnt=1; full re-sequence follows.
5. relock_req in FAIL and coincident with loss in RUN -> fail clears and the sequence restarts; in the coincident case lock_loss_cnt increments by 1, not 2.
6. rst asserted mid-QUALIFY and mid-RUN -> next cycle all outputs equal reset values, lock_loss_cnt=0, and the sequence restarts from ASSERT_RST.

Source files
------------

// File: rtl/soc_system_sys_pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// The sequencer side uses the slave modport. Whatever drives the lock and
// relock inputs (board glue or a bench) uses the master modport.
interface soc_system_sys_pll_reset_seq_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       reset_out_0;
  logic       reset_out_1;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_cnt;
  logic [3:0] retry_cnt;

  modport master (
    output pll_locked, relock_req,
    input  pll_rst, reset_out_0, reset_out_1, ready, fail, lock_loss_cnt, retry_cnt
  );

  modport slave (
    input  pll_locked, relock_req,
    output pll_rst, reset_out_0, reset_out_1, ready, fail, lock_loss_cnt, retry_cnt
  );
endinterface

// File: rtl/soc_system_sys_pll_reset_seq.sv
// PLL reset/lock sequencer. It pulses pll_rst and waits for a synchronized
// lock, then qualifies that lock over a stable window. After that it
// releases reset_out_0, and reset_out_1 follows a fixed gap later.
// A lock timeout retries up to MAX_RETRIES times and then parks in FAIL.
// Loss of lock or a relock request restarts the whole sequence.
module soc_system_sys_pll_reset_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int RST_RELEASE_GAP     = 8
) (
  input logic                          refclk,
  input logic                          rst,
  soc_system_sys_pll_reset_seq_if.slave bus
);

  // cnt is shared by the reset pulse, the stable window and the release gap.
  // It only needs to hold the largest terminal value of the three.
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > RST_RELEASE_GAP) ? PLL_RST_CYCLES : RST_RELEASE_GAP;
  localparam int CNT_MAX   = ((CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES) - 1;
  localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RST_RELEASE_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ASSERT_RST,
    ST_WAIT_LOCK,
    ST_QUALIFY,
    ST_RELEASE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic [1:0]       sync_q;
  logic             lk;

  logic pll_rst_q, pll_rst_d;
  logic rst0_q, rst0_d;
  logic rst1_q, rst1_d;
  logic ready_q, ready_d;
  logic fail_q, fail_d;

  logic lost, relock, timeout;

  assign lk      = sync_q[1];
  assign lost    = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lk;
  assign relock  = bus.relock_req && (state_q != ST_ASSERT_RST);
  assign timeout = (tmo_q == TMO_LAST);

  // State, counters, lock synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values, whatever order the statements are in.
    if (rst) begin
      state_q   <= ST_ASSERT_RST;
      cnt_q     <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      rst0_q    <= 1'b1;
      rst1_q    <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      sync_q    <= {sync_q[0], bus.pll_locked};
      pll_rst_q <= pll_rst_d;
      rst0_q    <= rst0_d;
      rst1_q    <= rst1_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state and counter update. Restarts (lock loss or relock) win over
  // everything, and entering RELEASE wins over a same-cycle timeout.
  always_comb begin
    // NOTE: every variable gets a default first, so that no path leaves it
    // unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (lost && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;

    if (lost || relock) begin
      state_d = ST_ASSERT_RST;
      cnt_d   = '0;
      if (relock) retry_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT_RST: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK, ST_QUALIFY: begin
          if ((state_q == ST_QUALIFY) && lk && (cnt_q == STABLE_LAST)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else if (timeout) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = ST_ASSERT_RST;
              cnt_d   = '0;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (state_q == ST_WAIT_LOCK) begin
              if (lk) begin
                state_d = ST_QUALIFY;
                cnt_d   = '0;
              end
            end else if (!lk) begin
              state_d = ST_WAIT_LOCK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN, ST_FAIL: ;
        default: state_d = ST_ASSERT_RST;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered. They switch on the
  // same edge as the state, so the reset-ordering invariants hold by construction.
  always_comb begin
    pll_rst_d = (state_d == ST_ASSERT_RST) || (state_d == ST_FAIL);
    rst0_d    = !((state_d == ST_RELEASE) || (state_d == ST_RUN));
    rst1_d    = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.reset_out_0   = rst0_q;
  assign bus.reset_out_1   = rst1_q;
  assign bus.ready         = ready_q;
  assign bus.fail          = fail_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.retry_cnt     = retry_q;

endmodule
